// File: rtl/serial_rx_msb.sv
// serial_rx_msb: MSB-first UART-style receiver with mid-bit sampling; define SERIAL_RX_PARITY_EN to expect an even-parity bit
module serial_rx_msb #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] HALF_T = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_B = BW'(DATA_W - 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t AFTER_DATA = PARITY;
    logic par_bit;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t            state;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [1:0]        sync;
    logic              rx_s;
    logic              bit_end;

    assign rx_s    = sync[1];
    assign bit_end = (clk_cnt == FULL_T);
    assign busy    = (state != IDLE);

    // two-flop synchronizer for the asynchronous line, idling high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= 2'b11;
        else        sync <= {sync[0], rx};
    end

    // frame FSM: start qualification, mid-bit sampling, result strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            if (!enb) begin
                state   <= IDLE;
                clk_cnt <= '0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        if (!rx_s) state <= START;
                    end
                    START: begin
                        if (clk_cnt == HALF_T) begin
                            clk_cnt <= '0;
                            state   <= rx_s ? IDLE : DATA;
                        end else clk_cnt <= clk_cnt + 1'b1;
                    end
                    DATA: begin
                        if (bit_end) begin
                            clk_cnt <= '0;
                            shift   <= {shift[DATA_W-2:0], rx_s};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_B) state <= AFTER_DATA;
                        end else clk_cnt <= clk_cnt + 1'b1;
                    end
`ifdef SERIAL_RX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            clk_cnt <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else clk_cnt <= clk_cnt + 1'b1;
                    end
`endif
                    STOP: begin
                        if (bit_end) begin
                            clk_cnt    <= '0;
                            data_out   <= shift;
`ifdef SERIAL_RX_PARITY_EN
                            parity_err <= (^shift) ^ par_bit;
`else
                            parity_err <= 1'b0;
`endif
                            frame_err  <= ~rx_s;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                        end else clk_cnt <= clk_cnt + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_rx_msb.sv
// tb_serial_rx_msb: directed vector bench for serial_rx_msb at CLKS_PER_BIT=4
module tb_serial_rx_msb;
    localparam int CPB = 4;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int LAT = 2 + CPB / 2 + (8 + 1 + int'(PAR)) * CPB + 1;

    typedef struct {
        logic [7:0] d;
        bit         par_ok;
        bit         stop;
        logic [7:0] exp_d;
        bit         exp_pe;
        bit         exp_fe;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enb = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, parity_err, frame_err, busy;

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         t_valid = 0;
    logic [7:0] cap_q[$];
    vec_t       vecs[6];

    serial_rx_msb #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .enb(enb), .rx(rx),
        .data_out(data_out), .data_valid(data_valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            pulses  = pulses + 1;
            t_valid = cyc;
            cap_q.push_back(data_out);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        if (PAR) drive_bit((^d) ^ ~par_ok);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;
        int q0;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h81, 1'b0, 1'b1, 8'h81, PAR,  1'b0};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 8'h00, PAR,  1'b1};
        vecs[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        idle(4);

        for (int i = 0; i < 6; i++) begin
            p0 = pulses;
            send_frame(vecs[i].d, vecs[i].par_ok, vecs[i].stop);
            idle(10);
            check($sformatf("vec%0d_pulses", i), 32'(pulses - p0), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d_parity_err", i), 32'(parity_err), 32'(vecs[i].exp_pe));
            check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end

        p0 = pulses;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_start", 32'(busy), 32'h1);
        repeat (6) @(negedge clk);
        check("glitch_busy_idle", 32'(busy), 32'h0);
        check("glitch_pulses", 32'(pulses - p0), 32'd0);
        check("glitch_data", 32'(data_out), 32'h5A);

        p0 = pulses;
        q0 = cap_q.size();
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b1, 1'b1);
        idle(10);
        check("b2b_pulses", 32'(pulses - p0), 32'd2);
        if (cap_q.size() >= q0 + 2) begin
            check("b2b_first", 32'(cap_q[q0]), 32'h55);
            check("b2b_second", 32'(cap_q[q0+1]), 32'hAA);
        end
        check("b2b_perr", 32'(parity_err), 32'h0);
        check("b2b_ferr", 32'(frame_err), 32'h0);

        p0 = pulses;
        drive_bit(1'b0);
        rx = 1'b1;
        repeat (4 * CPB + 2) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'h1);
        enb = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_after", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
        enb = 1'b1;
        idle(4);
        check("abort_no_pulse", 32'(pulses - p0), 32'd0);
        check("abort_data_held", 32'(data_out), 32'hAA);
        send_frame(8'h12, 1'b1, 1'b1);
        idle(10);
        check("after_abort_pulses", 32'(pulses - p0), 32'd1);
        check("after_abort_data", 32'(data_out), 32'h12);
        check("after_abort_perr", 32'(parity_err), 32'h0);

        send_frame(8'hA5, 1'b1, 1'b1);
        idle(10);
        check("latency_window", 32'((t_valid - t_start >= LAT - 1) && (t_valid - t_start <= LAT + 1)), 32'h1);
        check("latency_data", 32'(data_out), 32'hA5);

        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("midrst_data", 32'(data_out), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_valid", 32'(data_valid), 32'h0);
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        check("midrst_busy_idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_rx_msb.md
Name: serial_rx_msb

Overview:
- UART-style serial receiver; the receive end of the MSB-first serial frame our shift-out transmitter drives.
- Watches an idle-high line, detects the start bit, and samples each bit at mid-bit using a clock-divider counter.
- Shifts data in MSB first, checks parity and stop bit, and presents a parallel byte with a one-cycle valid strobe to downstream logic.

Parameters:
- DATA_W, 8, number of data bits per frame (>=2).
- CLKS_PER_BIT, 16, clk cycles per serial bit (even, >=4).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous reset, active low
- enb  input  1  receiver enable; low aborts any frame and holds the FSM in IDLE
- rx  input  1  serial line, idle high, asynchronous to clk
- data_out  output  DATA_W  last received byte, held until the next good or bad frame completes
- data_valid  output  1  one-cycle pulse; data_out/parity_err/frame_err updated this cycle
- parity_err  output  1  even-parity mismatch on last frame, held with data_out
- frame_err  output  1  stop bit sampled 0 on last frame, held with data_out
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset=0):
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - FSM=IDLE, counters=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer (sync reset value 1). All FSM decisions use the synchronized value rx_s.
- Frame on the line: start(0), D[DATA_W-1] first down to D[0], parity (even over data bits), stop(1).
- FSM states:
  - IDLE: bit counter=0.
    - If enb=1 and rx_s=0: go to START and clear the clock counter.
  - START: count CLKS_PER_BIT/2-1 cycles, then sample rx_s.
    - Sample 0: go to DATA and clear the clock counter.
    - Sample 1 (glitch): return to IDLE. No strobe, no output change.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s and shift it into the LSB of the shift register (shift left).
    - After DATA_W samples, go to PARITY.
  - PARITY: after CLKS_PER_BIT cycles, sample rx_s into the parity bit; go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - Next cycle: load data_out with the shift register.
    - parity_err = (^shift) ^ parity_bit.
    - frame_err = ~stop_sample.
    - data_valid=1 for exactly one clk.
    - Return to IDLE.
- Errored frames still update data_out and still pulse data_valid. Downstream logic qualifies them with the error flags.
- Back-to-back frames: a start edge may be detected in the first IDLE cycle after STOP, giving a minimum one-cycle turnaround.
- enb deasserted mid-frame: FSM goes to IDLE next clk and counters clear. No data_valid; outputs keep their previous values.
- reset asserted mid-frame: immediate return to the reset values above.
- Latency: data_valid rises 2 (sync) + CLKS_PER_BIT/2 + (DATA_W+2)*CLKS_PER_BIT + 1 clks after the line start edge (nominal, ±1 for edge alignment).
- Counter widths: $clog2(CLKS_PER_BIT) clock counter, $clog2(DATA_W+1) bit counter. No wrap beyond terminal counts.

Optional Feature:
- Macro SERIAL_RX_PARITY_EN.
- Defined: the frame contains the parity bit and the PARITY state exists; parity_err is computed as above.
- Not defined: the frame has no parity bit, DATA goes directly to STOP, parity_err is tied 0, and latency drops by CLKS_PER_BIT.

Test Plan:
- CLKS_PER_BIT=4, SERIAL_RX_PARITY_EN defined:
  - Drive frame 0xA5 (line 0,1,0,1,0,0,1,0,1,0,1) -> one data_valid pulse; data_out=0xA5, parity_err=0, frame_err=0; busy low afterwards.
  - Drive 0x81 with parity bit 1 (wrong; correct is 0) -> data_out=0x81, parity_err=1, frame_err=0.
  - Drive 0x3C with stop bit 0 -> data_out=0x3C, frame_err=1, data_valid pulsed once.
  - Drive a 1-clk low glitch while idle -> FSM returns to IDLE from START; no data_valid; data_out unchanged.
  - Send 0x55 then 0xAA with no idle gap -> two data_valid pulses, data_out 0x55 then 0xAA, no errors.
  - Deassert enb during data bit 4 of 0xFF -> no data_valid, busy=0 within 2 clks; a later 0x12 frame is received correctly.
